// File: rtl/tvs_uram_reader_if.sv
// URAM-side signal bundle for the TVS telemetry reader: read port plus the
// write-strobe snoop used to detect read-during-write collisions.
interface tvs_uram_reader_if;
    logic        r_en_o;
    logic [1:0]  r_addr_o;
    logic [15:0] r_data_i;
    logic        wr_en_i;
    logic [1:0]  wr_addr_i;

    modport master (
        output r_en_o,
        output r_addr_o,
        input  r_data_i,
        input  wr_en_i,
        input  wr_addr_i
    );

    modport slave (
        input  r_en_o,
        input  r_addr_o,
        output r_data_i,
        output wr_en_i,
        output wr_addr_i
    );
endinterface

// File: rtl/tvs_uram_reader.sv
// Read-side controller for the 4-entry TVS telemetry URAM: single-channel
// reads and 4-channel scans, with a stall on same-address writes.
module tvs_uram_reader #(
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    resetn_i,
    input  logic                    req_i,
    input  logic [1:0]              req_ch_i,
    input  logic                    req_all_i,
    tvs_uram_reader_if.master       uram,
    output logic                    busy_o,
    output logic [15:0]             data_o,
    output logic [1:0]              ch_o,
    output logic                    data_valid_o,
    output logic [63:0]             scan_data_o,
    output logic                    scan_done_o,
    output logic [1:0]              dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAITS = 2'd2
    } state_e;

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  cur_ch_q, cur_ch_d;
    logic        scan_q, scan_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic        busy_q, busy_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  ch_q, ch_d;
    logic        dv_q, dv_d;
    logic [63:0] scan_data_q, scan_data_d;
    logic        done_q, done_d;

    logic collide;
    logic rd_fire;

    // A write to the channel about to be read holds the read off for that cycle.
    assign collide = uram.wr_en_i && (uram.wr_addr_i == cur_ch_q);
    assign rd_fire = (state_q == ISSUE) && !collide;

    assign uram.r_en_o   = rd_fire;
    assign uram.r_addr_o = rd_fire ? cur_ch_q : 2'd0;

    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        scan_d      = scan_q;
        wait_cnt_d  = wait_cnt_q;
        data_d      = data_q;
        ch_d        = ch_q;
        dv_d        = 1'b0;
        scan_data_d = scan_data_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_all_i) begin
                    state_d  = ISSUE;
                    cur_ch_d = 2'd0;
                    scan_d   = 1'b1;
                end else if (req_i) begin
                    state_d  = ISSUE;
                    cur_ch_d = req_ch_i;
                    scan_d   = 1'b0;
                end
            end
            ISSUE: begin
                if (!collide) begin
                    state_d    = WAITS;
                    wait_cnt_d = WAIT_INIT;
                end
            end
            WAITS: begin
                if (wait_cnt_q == 2'd0) begin
                    data_d = uram.r_data_i;
                    ch_d   = cur_ch_q;
                    dv_d   = 1'b1;
                    if (scan_q) begin
                        scan_data_d[16*cur_ch_q +: 16] = uram.r_data_i;
                    end
                    if (scan_q && (cur_ch_q != 2'd3)) begin
                        cur_ch_d = cur_ch_q + 2'd1;
                        state_d  = ISSUE;
                    end else begin
                        state_d = IDLE;
                        done_d  = scan_q;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= IDLE;
            cur_ch_q    <= 2'd0;
            scan_q      <= 1'b0;
            wait_cnt_q  <= 2'd0;
            busy_q      <= 1'b0;
            data_q      <= 16'd0;
            ch_q        <= 2'd0;
            dv_q        <= 1'b0;
            scan_data_q <= 64'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            scan_q      <= scan_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_q      <= busy_d;
            data_q      <= data_d;
            ch_q        <= ch_d;
            dv_q        <= dv_d;
            scan_data_q <= scan_data_d;
            done_q      <= done_d;
        end
    end

    assign busy_o       = busy_q;
    assign data_o       = data_q;
    assign ch_o         = ch_q;
    assign data_valid_o = dv_q;
    assign scan_data_o  = scan_data_q;
    assign scan_done_o  = done_q;
    assign dbg_state_o  = state_q;

endmodule

// File: doc/tvs_uram_reader.md
Name: tvs_uram_reader

Overview:
- Read-side controller for the TVS telemetry URAM: 4 entries (addr = TVS channel 0..3), 16-bit values, filled by the TVS write controller.
- Serves single-channel reads and 4-channel scans to the slow-control/readout logic.
- Handles URAM read latency and stalls around same-address writes.
- Sits between the URAM read port and the register interface.

Parameters:
- RD_LAT, 1, URAM read latency in clk cycles from r_en_o to valid r_data_i; legal 1..3.

Ports:
- clk  input  1  system clock
- resetn_i  input  1  async active-low reset
- req_i  input  1  single-channel read request, sampled only when busy_o=0
- req_ch_i  input  2  channel for req_i
- req_all_i  input  1  4-channel scan request, sampled only when busy_o=0
- wr_en_i  input  1  write strobe from TVS writer (URAM w_en)
- wr_addr_i  input  2  write address from TVS writer
- r_en_o  output  1  URAM read enable
- r_addr_o  output  2  URAM read address
- r_data_i  input  16  URAM read data
- busy_o  output  1  high while a request is in progress
- data_o  output  16  last value read
- ch_o  output  2  channel of data_o
- data_valid_o  output  1  one-cycle pulse, data_o/ch_o new
- scan_data_o  output  64  packed scan result, channel n at bits [16n+15:16n]
- scan_done_o  output  1  one-cycle pulse at end of scan

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset resetn_i is asynchronous, active-low.
  - On reset all outputs are 0 and the FSM is in IDLE.
  - Reset mid-operation aborts the transaction: no data_valid_o and no scan_done_o for it.
- FSM states:
  - IDLE:
    - req_all_i=1 → ISSUE, cur_ch=0, scan=1. req_all_i wins if req_i is also high.
    - Else req_i=1 → ISSUE, cur_ch=req_ch_i, scan=0.
    - Else stay in IDLE.
  - ISSUE:
    - If wr_en_i=1 and wr_addr_i==cur_ch: r_en_o=0 and stay in ISSUE (read-during-write stall, one cycle per colliding write).
    - Else r_en_o=1, r_addr_o=cur_ch for exactly that cycle, then → WAIT with wait_cnt=RD_LAT-1.
  - WAIT:
    - Decrement wait_cnt each cycle.
    - When wait_cnt==0, r_data_i is valid that cycle (RD_LAT cycles after the r_en_o cycle). Register it: data_o=r_data_i, ch_o=cur_ch, data_valid_o=1 next cycle.
    - Scan mode: also write scan_data_o slice cur_ch.
    - If scan and cur_ch≠3: cur_ch+1, → ISSUE.
    - Else → IDLE, with scan_done_o=1 in the same cycle as the last data_valid_o when scan=1.
- busy_o:
  - busy_o = (state≠IDLE), registered.
  - Requests while busy_o=1 are ignored, not queued.
  - A request is accepted in the cycle data_valid_o pulses, since the FSM is back in IDLE.
- Latency:
  - Single read: req cycle 0, r_en_o cycle 1, data_valid_o cycle RD_LAT+2 with no stalls.
  - Scan: 4 back-to-back reads; data_valid_o pulses at RD_LAT+2+k·(RD_LAT+1), k=0..3.
  - Each stall cycle adds 1.
- Output holds:
  - data_o, ch_o and scan_data_o hold their values until overwritten.
  - A single-channel read never modifies scan_data_o.
- data_valid_o and scan_done_o are never high for more than one cycle.
- r_en_o is never high outside ISSUE.

Test Plan:
- Reset then idle; URAM holds ch2=0x1234; req_i, req_ch_i=2, RD_LAT=1 → r_en_o/r_addr_o=2 at cycle 1; data_o=0x1234, ch_o=2, data_valid_o at cycle 3; busy_o high cycles 1–2.
- URAM {0xAAAA,0xBBBB,0xCCCC,0xDDDD}; req_all_i with RD_LAT=2 → 4 data_valid_o pulses at cycles 4,7,10,13; scan_data_o=0xDDDDCCCCBBBBAAAA; scan_done_o only at cycle 13.
- During ISSUE for ch1, wr_en_i=1, wr_addr_i=1 for one cycle → r_en_o delayed one cycle, data_valid_o one cycle later. Repeat with wr_addr_i=3 → no stall.
- Collision and busy handling:
  - req_i and req_all_i in the same cycle → scan executes.
  - req_i pulsed while busy_o=1 → ignored; exactly 1 data_valid_o.
  - req_i in the data_valid_o cycle → accepted.
- Deassert resetn_i during WAIT of a scan at ch2 → all outputs 0 immediately; no scan_done_o; after release a new req_i completes normally.
- Sweep RD_LAT=1,2,3 with random requests against a URAM model → every data_o matches the model and the latency equals RD_LAT+2 plus stalls.
